wb_commit: RTL and testbench



---
 rtl/wb_commit.sv | 181 ++++++++++++++++++
 tb/tb_wb_commit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Writeback commit stage: arbitrates ALU/load/FPU results onto the integer and
// FP register-file write ports through one small commit queue per file.

module wb_commit_lane #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_v,
   input  logic [4:0]    a_dst,
   input  logic [31:0]   a_data,
   input  logic          b_v,
   input  logic [4:0]    b_dst,
   input  logic [31:0]   b_data,
   output logic [CW-1:0] cnt,
   output logic          wr,
   output logic [4:0]    wr_dst,
   output logic [31:0]   wr_data
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic          wr_q, wr_d;
   logic [4:0]    dst_q, dst_d;
   logic [31:0]   data_q, data_d;
   logic [4:0]    qdst_q [DEPTH];
   logic [4:0]    qdst_d [DEPTH];
   logic [31:0]   qdata_q [DEPTH];
   logic [31:0]   qdata_d [DEPTH];

   logic          f_v, s_v;
   logic [4:0]    f_dst;
   logic [31:0]   f_data;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // a is the older source; b only becomes second when both are present
   assign f_v    = a_v | b_v;
   assign f_dst  = a_v ? a_dst : b_dst;
   assign f_data = a_v ? a_data : b_data;
   assign s_v    = a_v & b_v;

   always_comb begin
      cnt_d   = cnt_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      wr_d    = 1'b0;
      dst_d   = dst_q;
      data_d  = data_q;
      qdst_d  = qdst_q;
      qdata_d = qdata_q;
      if (cnt_q == '0) begin
         if (f_v) begin
            wr_d   = 1'b1;
            dst_d  = f_dst;
            data_d = f_data;
         end
         if (s_v) begin
            qdst_d[wptr_q]  = b_dst;
            qdata_d[wptr_q] = b_data;
            wptr_d          = inc(wptr_q);
            cnt_d           = cnt_q + 1'b1;
         end
      end else begin
         wr_d   = 1'b1;
         dst_d  = qdst_q[rptr_q];
         data_d = qdata_q[rptr_q];
         rptr_d = inc(rptr_q);
         if (f_v) begin
            qdst_d[wptr_q]  = f_dst;
            qdata_d[wptr_q] = f_data;
            wptr_d          = inc(wptr_q);
         end
         if (s_v) begin
            qdst_d[inc(wptr_q)]  = b_dst;
            qdata_d[inc(wptr_q)] = b_data;
            wptr_d               = inc(inc(wptr_q));
         end
         cnt_d = cnt_q - CW'(1) + CW'(f_v) + CW'(s_v);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
         wr_q   <= 1'b0;
         dst_q  <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         wr_q   <= wr_d;
         dst_q  <= dst_d;
         data_q <= data_d;
      end
   end

   // storage needs no reset: entries are only read while counted
   always_ff @(posedge clk) begin
      qdst_q  <= qdst_d;
      qdata_q <= qdata_d;
   end

   assign cnt     = cnt_q;
   assign wr      = wr_q;
   assign wr_dst  = dst_q;
   assign wr_data = data_q;
endmodule

module wb_commit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_dst,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic        mem_fp,
   input  logic [4:0]  mem_dst,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   input  logic        fpu_valid,
   input  logic [4:0]  fpu_dst_i,
   input  logic [31:0] fpu_data,
   output logic        fpu_ready,
   output logic        write,
   output logic [4:0]  dst,
   output logic [31:0] rd,
   output logic        fp_write,
   output logic [4:0]  fpu_dst,
   output logic [31:0] fd,
   output logic        int_idle,
   output logic        fp_idle
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LIM1 = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LIM2 = CW'(DEPTH - 2);

   logic [CW-1:0] int_cnt, fp_cnt;
   logic          mem_acc;
   logic          int_a_v, int_b_v, fp_a_v, fp_b_v;

   // readies come only from registered counts, never from any valid
   assign mem_ready = !reset && ((mem_fp ? fp_cnt : int_cnt) <= LIM1);
   assign alu_ready = !reset && (int_cnt <= LIM2);
   assign fpu_ready = !reset && (fp_cnt <= LIM2);

   assign mem_acc = mem_valid && mem_ready;
   // r0 writes are accepted but dropped here so they never occupy a slot
   assign int_a_v = mem_acc && !mem_fp && (mem_dst != 5'd0);
   assign int_b_v = alu_valid && alu_ready && (alu_dst != 5'd0);
   assign fp_a_v  = mem_acc && mem_fp;
   assign fp_b_v  = fpu_valid && fpu_ready;

   wb_commit_lane #(.DEPTH(DEPTH)) u_int (
      .clk(clk), .reset(reset),
      .a_v(int_a_v), .a_dst(mem_dst), .a_data(mem_data),
      .b_v(int_b_v), .b_dst(alu_dst), .b_data(alu_data),
      .cnt(int_cnt), .wr(write), .wr_dst(dst), .wr_data(rd)
   );

   wb_commit_lane #(.DEPTH(DEPTH)) u_fp (
      .clk(clk), .reset(reset),
      .a_v(fp_a_v), .a_dst(mem_dst), .a_data(mem_data),
      .b_v(fp_b_v), .b_dst(fpu_dst_i), .b_data(fpu_data),
      .cnt(fp_cnt), .wr(fp_write), .wr_dst(fpu_dst), .wr_data(fd)
   );

   assign int_idle = (int_cnt == '0) && !write;
   assign fp_idle  = (fp_cnt == '0) && !fp_write;
endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: stimulus pushes expected commits per lane,
// a negedge monitor pops and compares every write-port cycle.

module tb_wb_commit;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        alu_valid = 0, mem_valid = 0, mem_fp = 0, fpu_valid = 0;
   logic [4:0]  alu_dst = 0, mem_dst = 0, fpu_dst_i = 0;
   logic [31:0] alu_data = 0, mem_data = 0, fpu_data = 0;
   logic        alu_ready, mem_ready, fpu_ready;
   logic        write, fp_write, int_idle, fp_idle;
   logic [4:0]  dst, fpu_dst;
   logic [31:0] rd, fd;

   typedef struct packed {
      logic [4:0]  dst;
      logic [31:0] data;
   } res_t;

   res_t int_q[$];
   res_t fp_q[$];
   int checks = 0, failures = 0;
   logic [4:0]  last_dst = 0, last_fdst = 0;
   logic [31:0] last_rd = 0, last_fd = 0;

   wb_commit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_fp(mem_fp), .mem_dst(mem_dst), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .fpu_valid(fpu_valid), .fpu_dst_i(fpu_dst_i), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
      .write(write), .dst(dst), .rd(rd),
      .fp_write(fp_write), .fpu_dst(fpu_dst), .fd(fd),
      .int_idle(int_idle), .fp_idle(fp_idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Every pending result commits one per cycle, so the lane must strobe
   // exactly when its scoreboard queue is non-empty.
   always @(negedge clk) begin
      res_t r;
      if (reset) begin
         int_q.delete();
         fp_q.delete();
         chk("rst_write", 32'(write), 32'd0);
         chk("rst_fp_write", 32'(fp_write), 32'd0);
         chk("rst_dst", 32'(dst), 32'd0);
         chk("rst_rd", rd, 32'd0);
         chk("rst_fpu_dst", 32'(fpu_dst), 32'd0);
         chk("rst_fd", fd, 32'd0);
         chk("rst_int_idle", 32'(int_idle), 32'd1);
         chk("rst_fp_idle", 32'(fp_idle), 32'd1);
         last_dst = 0; last_rd = 0; last_fdst = 0; last_fd = 0;
      end else begin
         chk("int_idle", 32'(int_idle), 32'(int_q.size() == 0));
         chk("write", 32'(write), 32'(int_q.size() != 0));
         if (write && int_q.size() != 0) begin
            r = int_q.pop_front();
            chk("dst", 32'(dst), 32'(r.dst));
            chk("rd", rd, r.data);
            last_dst = r.dst; last_rd = r.data;
         end else if (!write) begin
            chk("dst_hold", 32'(dst), 32'(last_dst));
            chk("rd_hold", rd, last_rd);
         end
         chk("fp_idle", 32'(fp_idle), 32'(fp_q.size() == 0));
         chk("fp_write", 32'(fp_write), 32'(fp_q.size() != 0));
         if (fp_write && fp_q.size() != 0) begin
            r = fp_q.pop_front();
            chk("fpu_dst", 32'(fpu_dst), 32'(r.dst));
            chk("fd", fd, r.data);
            last_fdst = r.dst; last_fd = r.data;
         end else if (!fp_write) begin
            chk("fpu_dst_hold", 32'(fpu_dst), 32'(last_fdst));
            chk("fd_hold", fd, last_fd);
         end
      end
   end

   // One cycle of stimulus; the queue sizes after the monitor's pop are the
   // number of results still waiting behind the write port.
   task automatic drive(input logic rst, input logic mv, input logic mfp, input logic [4:0] mdst,
                        input logic [31:0] mdata, input logic av, input logic [4:0] adst,
                        input logic [31:0] adata, input logic fv, input logic [4:0] fdst,
                        input logic [31:0] fdata);
      logic e_mem, e_alu, e_fpu;
      @(negedge clk); #1;
      reset = rst;
      mem_valid = mv; mem_fp = mfp; mem_dst = mdst; mem_data = mdata;
      alu_valid = av; alu_dst = adst; alu_data = adata;
      fpu_valid = fv; fpu_dst_i = fdst; fpu_data = fdata;
      #1;
      e_mem = !rst && ((mfp ? fp_q.size() : int_q.size()) <= DEPTH - 1);
      e_alu = !rst && (int_q.size() <= DEPTH - 2);
      e_fpu = !rst && (fp_q.size() <= DEPTH - 2);
      chk("mem_ready", 32'(mem_ready), 32'(e_mem));
      chk("alu_ready", 32'(alu_ready), 32'(e_alu));
      chk("fpu_ready", 32'(fpu_ready), 32'(e_fpu));
      if (mv && e_mem) begin
         if (mfp) fp_q.push_back({mdst, mdata});
         else if (mdst != 5'd0) int_q.push_back({mdst, mdata});
      end
      if (av && e_alu && adst != 5'd0) int_q.push_back({adst, adata});
      if (fv && e_fpu) fp_q.push_back({fdst, fdata});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [4:0] rdst();
      return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
   endfunction

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // single ALU result into empty lane
      drive(0, 0, 0, 0, 0, 1, 5, 32'h12345678, 0, 0, 0);
      idle(3);
      // mem and alu same cycle: mem first
      drive(0, 1, 0, 3, 32'hAAAA0000, 1, 4, 32'h0000BBBB, 0, 0, 0);
      idle(3);
      // r0 destination held valid
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0, 32'hDEAD0000 + i, 0, 0, 0);
      idle(2);
      // back-to-back paired INT requests, then probe both mem targets when full
      for (int i = 0; i < 4; i++)
         drive(0, 1, 0, 5'(8 + i), 32'h100 + i, 1, 5'(16 + i), 32'h200 + i, 0, 0, 0);
      drive(0, 1, 1, 9, 32'h300, 1, 20, 32'h301, 0, 0, 0);
      drive(0, 1, 0, 10, 32'h302, 0, 0, 0, 0, 0, 0);
      idle(8);
      // both lanes at once, FP register 0 is ordinary
      drive(0, 1, 1, 0, 32'h3F800000, 1, 7, 32'd1, 1, 2, 32'h40000000);
      idle(3);
      // reset mid-drain
      for (int i = 0; i < 2; i++)
         drive(0, 1, 0, 5'(1 + i), 32'h500 + i, 1, 5'(11 + i), 32'h600 + i, 0, 0, 0);
      drive(1, 1, 0, 6, 32'h777, 1, 6, 32'h778, 1, 6, 32'h779);
      idle(2);
      drive(0, 0, 0, 0, 0, 1, 9, 32'hCAFEF00D, 0, 0, 0);
      idle(3);
      // randomized traffic, alternating light and heavy load
      for (int i = 0; i < 3000; i++) begin
         int p;
         p = ((i / 300) % 2 == 1) ? 90 : 35;
         drive($urandom_range(0, 199) == 0,
               $urandom_range(0, 99) < p, 1'($urandom_range(0, 1)), rdst(), $urandom(),
               $urandom_range(0, 99) < p, rdst(), $urandom(),
               $urandom_range(0, 99) < p, 5'($urandom_range(0, 31)), $urandom());
      end
      idle(10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
